// File: rtl/fifo_param.sv
// -----------------------------------------------------------------------------
// fifo_param
// Parametrised single-clock FIFO with push/pop interface, occupancy count,
// programmable almost-empty/almost-full thresholds and sticky error flags.
//
// Optional feature macro: FIFO_FWFT_EN
//   undefined : registered read, data_out loads the head word on the edge an
//               accepted pop occurs and holds until the next accepted pop.
//   defined   : first-word-fall-through, data_out continuously shows mem[rptr]
//               (don't-care while empty).
//
// Parameters:
//   WIDTH     data word width (>=1)
//   DEPTH     entries, power of 2, >=4
//   AE_MARGIN almost_empty when count <= AE_MARGIN
//   AF_MARGIN almost_full  when count >= DEPTH-AF_MARGIN
//
// Ports:
//   clk          system clock, rising edge
//   reset_n      synchronous active-low reset
//   push         write request, data_in captured on the same edge
//   pop          read request
//   data_in      write data
//   err_clr      clears ovf_sticky/udf_sticky on the next edge
//   data_out     read data
//   empty        count == 0
//   almost_empty count <= AE_MARGIN
//   almost_full  count >= DEPTH-AF_MARGIN
//   full         count == DEPTH
//   count        occupancy 0..DEPTH
//   error        one-cycle pulse on overflow or underflow
//   ovf_sticky   latched overflow
//   udf_sticky   latched underflow
// -----------------------------------------------------------------------------
module fifo_param #(
  parameter int WIDTH     = 32,
  parameter int DEPTH     = 16,
  parameter int AE_MARGIN = 2,
  parameter int AF_MARGIN = 2
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic                       push,
  input  logic                       pop,
  input  logic [WIDTH-1:0]           data_in,
  input  logic                       err_clr,
  output logic [WIDTH-1:0]           data_out,
  output logic                       empty,
  output logic                       almost_empty,
  output logic                       almost_full,
  output logic                       full,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       error,
  output logic                       ovf_sticky,
  output logic                       udf_sticky
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);
  localparam logic [CW-1:0] AE_TH    = CW'(AE_MARGIN);
  localparam logic [CW-1:0] AF_TH    = CW'(DEPTH - AF_MARGIN);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wptr;
  logic [AW-1:0]    rptr;

  logic push_ok;
  logic pop_ok;
  logic ovf_ev;
  logic udf_ev;

  // Flags come from the registered count only.
  assign empty        = (count == '0);
  assign full         = (count == FULL_CNT);
  assign almost_empty = (count <= AE_TH);
  assign almost_full  = (count >= AF_TH);

  // A pop frees a slot on the same edge, so push is accepted when full if a
  // pop accompanies it (pop is always legal when full since DEPTH >= 4).
  assign push_ok = push && (!full || pop);
  assign pop_ok  = pop && !empty;
  assign ovf_ev  = push && full && !pop;
  assign udf_ev  = pop && empty;

  // Storage is never cleared; reset only blocks the write on its edge.
  always_ff @(posedge clk) begin
    if (reset_n && push_ok) begin
      mem[wptr] <= data_in;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      wptr       <= '0;
      rptr       <= '0;
      count      <= '0;
      error      <= 1'b0;
      ovf_sticky <= 1'b0;
      udf_sticky <= 1'b0;
    end else begin
      if (push_ok) wptr <= wptr + AW'(1);
      if (pop_ok)  rptr <= rptr + AW'(1);
      case ({push_ok, pop_ok})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
      error      <= ovf_ev | udf_ev;
      // A new violation in the same cycle as err_clr keeps the flag set.
      ovf_sticky <= ovf_ev | (ovf_sticky & ~err_clr);
      udf_sticky <= udf_ev | (udf_sticky & ~err_clr);
    end
  end

`ifdef FIFO_FWFT_EN
  assign data_out = mem[rptr];
`else
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      data_out <= '0;
    end else if (pop_ok) begin
      data_out <= mem[rptr];
    end
  end
`endif

endmodule

// File: tb/tb_fifo_param.sv
module tb_fifo_param;

  localparam int WIDTH = 8;
  localparam int DEPTH = 8;
  localparam int AE_M  = 2;
  localparam int AF_M  = 2;

  logic             clk = 1'b0;
  logic             reset_n;
  logic             push;
  logic             pop;
  logic [WIDTH-1:0] data_in;
  logic             err_clr;
  logic [WIDTH-1:0] data_out;
  logic             empty;
  logic             almost_empty;
  logic             almost_full;
  logic             full;
  logic [3:0]       count;
  logic             error;
  logic             ovf_sticky;
  logic             udf_sticky;

  int n_chk  = 0;
  int n_fail = 0;

  // Scoreboard: words enter when an accepted push is driven, leave on pop.
  logic [WIDTH-1:0] sb[$];
  logic [WIDTH-1:0] m_dout;
  bit               m_err, m_ovf, m_udf;

  fifo_param #(.WIDTH(WIDTH), .DEPTH(DEPTH), .AE_MARGIN(AE_M), .AF_MARGIN(AF_M)) dut (
    .clk(clk), .reset_n(reset_n), .push(push), .pop(pop), .data_in(data_in),
    .err_clr(err_clr), .data_out(data_out), .empty(empty),
    .almost_empty(almost_empty), .almost_full(almost_full), .full(full),
    .count(count), .error(error), .ovf_sticky(ovf_sticky), .udf_sticky(udf_sticky)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic check_all();
    int n;
    n = sb.size();
    check("count", 32'(count), 32'(n));
    check("empty", 32'(empty), 32'(n == 0));
    check("full", 32'(full), 32'(n == DEPTH));
    check("almost_empty", 32'(almost_empty), 32'(n <= AE_M));
    check("almost_full", 32'(almost_full), 32'(n >= DEPTH - AF_M));
    check("error", 32'(error), 32'(m_err));
    check("ovf_sticky", 32'(ovf_sticky), 32'(m_ovf));
    check("udf_sticky", 32'(udf_sticky), 32'(m_udf));
`ifdef FIFO_FWFT_EN
    if (n != 0) check("data_out", 32'(data_out), 32'(sb[0]));
`else
    check("data_out", 32'(data_out), 32'(m_dout));
`endif
  endtask

  // Advance one clock: update the reference model from the inputs present at
  // the edge, then sample the DUT 1 time unit later.
  task automatic tick();
    bit f, e, pok, wok, ovf_ev, udf_ev;
    f = (sb.size() == DEPTH);
    e = (sb.size() == 0);
    @(posedge clk);
    if (!reset_n) begin
      sb.delete();
      m_dout = '0;
      m_err  = 0;
      m_ovf  = 0;
      m_udf  = 0;
    end else begin
      pok    = pop && !e;
      wok    = push && (!f || pop);
      ovf_ev = push && f && !pop;
      udf_ev = pop && e;
      if (pok) m_dout = sb.pop_front();
      if (wok) sb.push_back(data_in);
      m_err = ovf_ev || udf_ev;
      m_ovf = ovf_ev || (m_ovf && !err_clr);
      m_udf = udf_ev || (m_udf && !err_clr);
    end
    #1;
    check_all();
  endtask

  task automatic drive(input bit p, input bit q, input logic [WIDTH-1:0] d, input bit c);
    push    = p;
    pop     = q;
    data_in = d;
    err_clr = c;
    tick();
  endtask

  initial begin
    reset_n = 1'b0;
    push = 0; pop = 0; data_in = '0; err_clr = 0;
    m_dout = '0;

    // Reset held 5 cycles then released.
    for (int i = 0; i < 5; i++) tick();
    reset_n = 1'b1;
    drive(0, 0, 8'h00, 0);
    check("rst_count", 32'(count), 0);
    check("rst_data_out", 32'(data_out), 0);

    // Fill with 0x11..0x18 then overflow.
    for (int i = 0; i < DEPTH; i++) begin
      drive(1, 0, 8'(8'h11 + i), 0);
      check("af_at_fill", 32'(almost_full), 32'(i + 1 >= 6));
    end
    drive(1, 0, 8'h99, 0);
    check("ovf_pulse", 32'(error), 1);
    check("ovf_count_hold", 32'(count), 8);
    drive(0, 0, 8'h00, 0);
    check("ovf_pulse_end", 32'(error), 0);

`ifndef FIFO_FWFT_EN
    // Drain in order, then underflow keeps data_out.
    for (int i = 0; i < DEPTH; i++) begin
      drive(0, 1, 8'h00, 0);
      check("pop_order", 32'(data_out), 32'(8'h11 + i));
    end
    drive(0, 1, 8'h00, 0);
    check("udf_pulse", 32'(error), 1);
    check("udf_hold_data", 32'(data_out), 32'h18);
`else
    for (int i = 0; i < DEPTH; i++) begin
      check("fwft_head", 32'(data_out), 32'(8'h11 + i));
      drive(0, 1, 8'h00, 0);
    end
    drive(0, 1, 8'h00, 0);
    check("udf_pulse", 32'(error), 1);
`endif
    check("udf_sticky_set", 32'(udf_sticky), 1);

    // Full with simultaneous push/pop: count stays, 0xAA ends up last.
    for (int i = 0; i < DEPTH; i++) drive(1, 0, 8'(8'h21 + i), 0);
    drive(1, 1, 8'hAA, 0);
    check("full_pp_count", 32'(count), 8);
    check("full_pp_noerr", 32'(error), 0);
    for (int i = 0; i < DEPTH; i++) begin
`ifdef FIFO_FWFT_EN
      if (i == DEPTH - 1) check("last_word_aa", 32'(data_out), 32'hAA);
`endif
      drive(0, 1, 8'h00, 0);
    end
`ifndef FIFO_FWFT_EN
    check("last_word_aa", 32'(data_out), 32'hAA);
`endif

    // Empty with push+pop: push accepted, pop is an underflow.
    drive(1, 1, 8'h3C, 0);
    check("empty_pp_count", 32'(count), 1);
    check("empty_pp_err", 32'(error), 1);
    drive(0, 1, 8'h00, 0);

    // Interleaved traffic with pointer wrap.
    for (int i = 0; i < 12; i++) begin
      drive(1, 0, 8'($urandom_range(0, 255)), 0);
      drive(0, 1, 8'h00, 0);
    end
    for (int i = 0; i < 40; i++)
      drive(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
            8'($urandom_range(0, 255)), 0);
    while (sb.size() != 0) drive(0, 1, 8'h00, 0);

    // Sticky clear, then set-wins with err_clr.
    drive(0, 0, 8'h00, 1);
    check("clr_ovf", 32'(ovf_sticky), 0);
    check("clr_udf", 32'(udf_sticky), 0);
    drive(0, 1, 8'h00, 1);
    check("set_wins_udf", 32'(udf_sticky), 1);
    drive(0, 0, 8'h00, 1);

    // Push into empty; visible next cycle.
    drive(1, 0, 8'h5C, 0);
    check("push_empty_nonempty", 32'(empty), 0);
`ifdef FIFO_FWFT_EN
    check("fwft_5c", 32'(data_out), 32'h5C);
`endif
    drive(0, 1, 8'h00, 0);
    check("pop_to_empty", 32'(empty), 1);
`ifndef FIFO_FWFT_EN
    check("reg_5c", 32'(data_out), 32'h5C);
`endif

    // Mid-operation reset with count 5, reset overriding a push.
    for (int i = 0; i < 5; i++) drive(1, 0, 8'(8'h60 + i), 0);
    check("pre_rst_count", 32'(count), 5);
    reset_n = 1'b0;
    drive(1, 0, 8'h77, 0);
    check("mid_rst_count", 32'(count), 0);
    reset_n = 1'b1;
    drive(0, 0, 8'h00, 0);
    check("post_rst_empty", 32'(empty), 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/fifo_param.md
Name: fifo_param

Overview:
- Parametrised successor to the fixed-size synchronous FIFO: single clock, push/pop interface.
- Adds generic width and depth, programmable almost-full/almost-empty margins and an occupancy count output.
- Adds separate sticky overflow/underflow flags with clear, plus an optional first-word-fall-through read mode.
- Sits between a producer and a consumer in the same clock domain; drop-in for the existing FIFO interface with extra ports.

Parameters:
WIDTH, 32, data word width in bits (>=1)
DEPTH, 16, number of entries; power of 2, >=4
AE_MARGIN, 2, almost_empty asserted when count <= AE_MARGIN (1..DEPTH-2)
AF_MARGIN, 2, almost_full asserted when count >= DEPTH-AF_MARGIN (1..DEPTH-2)

Ports:
clk  in  1  system clock, all logic on rising edge
reset_n  in  1  synchronous active-low reset, sampled on posedge clk
push  in  1  write request; data_in captured on the same edge
pop  in  1  read request
data_in  in  WIDTH  write data
err_clr  in  1  clears the sticky error flags
data_out  out  WIDTH  read data
empty  out  1  count == 0
almost_empty  out  1  count <= AE_MARGIN
almost_full  out  1  count >= DEPTH-AF_MARGIN
full  out  1  count == DEPTH
count  out  $clog2(DEPTH)+1  current occupancy, 0..DEPTH
error  out  1  one-cycle pulse on any illegal request
ovf_sticky  out  1  latched overflow
udf_sticky  out  1  latched underflow

Behaviour:
- Reset (reset_n==0 at posedge):
  - Read/write pointers, count, error, ovf_sticky and udf_sticky all go to 0.
  - data_out goes to 0.
  - Resulting flag values: empty=1, almost_empty=1, almost_full=0, full=0.
  - Memory contents are not cleared.
  - Reset overrides push/pop on the same edge; mid-operation reset discards all stored data.
- Storage: circular buffer of DEPTH words. Pointers are $clog2(DEPTH) bits and wrap naturally from DEPTH-1 to 0.
- Flags: decoded combinationally from the registered count, so they reflect state after the last edge.
- Accepted push: push && (!full || pop). Writes mem[wptr], then wptr+1.
- Accepted pop: pop && !empty. Reads the head, then rptr+1.
- count update: +1 on push only, -1 on pop only, unchanged when both are accepted.
- Overflow: push && full && !pop.
  - Write dropped; state unchanged.
  - error=1 for one cycle; ovf_sticky=1.
- Underflow: pop && empty.
  - No read; data_out holds its value.
  - error=1 for one cycle; udf_sticky=1.
  - A simultaneous push is still accepted.
- Push and pop when full: both accepted, count stays DEPTH, no error.
- Push and pop when empty: push accepted, pop is an underflow.
- Sticky flags:
  - err_clr=1 clears both on the next edge.
  - If a new violation occurs in the same cycle as err_clr, the set wins.
- Default read (registered): data_out is updated with the head word on the edge where the pop is accepted, i.e. valid 1 cycle after the pop request. It holds until the next accepted pop.

Optional Feature:
- Macro: FIFO_FWFT_EN.
- Defined (first-word-fall-through):
  - data_out continuously presents mem[rptr], zero-latency read.
  - Value is valid whenever empty==0 and is don't-care when empty.
  - pop acknowledges the current word and advances rptr; the next word appears after that edge.
  - Overflow/underflow rules are unchanged.
  - A word pushed into an empty FIFO is visible on data_out the cycle after the push.
- Not defined: registered read as specified under Behaviour; no fall-through logic is synthesised.

Test Plan (WIDTH=8, DEPTH=8, AE_MARGIN=2, AF_MARGIN=2):
- Reset held 5 cycles, then released -> count=0, empty=1, almost_empty=1, full=0, error=0, data_out=0.
- Push 0x11..0x18 (8 words), then 1 more push -> count=8, full=1, almost_full from count=6; the 9th push gives an error pulse, ovf_sticky=1, count stays 8.
- Pop 8 times (non-FWFT) -> data_out=0x11..0x18, each 1 cycle after its pop; then pop again -> error pulse, udf_sticky=1, data_out holds 0x18.
- Fill to 8, then push 0xAA with pop on the same cycle -> count stays 8, no error; after draining, 0xAA is the last word.
- Push 12 and pop 12 interleaved -> pointer wrap occurs, data order preserved; err_clr=1 -> both sticky flags 0 next cycle.
- FIFO_FWFT_EN defined: push 0x5C into empty FIFO -> data_out=0x5C, empty=0 next cycle with no pop; pop -> empty=1. Reset asserted with count=5 -> count=0 on the next edge.
